// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered pixel
// coordinates, data enable, sync pulses and line/frame strobes.
module video_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 160,
  parameter int H_SYNC   = 20,
  parameter int H_BP     = 140,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 12,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_totals
      $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
    end
  endgenerate

  // 13-bit band limits so a 4096-wide raster cannot wrap the comparisons.
  localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG   = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG   = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt, v_cnt;
  logic [11:0] h_nxt, v_nxt;
  logic [12:0] h_ext, v_ext;
  logic        de_nxt, hs_act, vs_act;

  always_comb begin
    h_nxt = h_cnt + 12'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST[11:0]) begin
      h_nxt = 12'd0;
      v_nxt = (v_cnt == V_LAST[11:0]) ? 12'd0 : v_cnt + 12'd1;
    end
    h_ext  = {1'b0, h_nxt};
    v_ext  = {1'b0, v_nxt};
    de_nxt = (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_act = (h_ext >= HS_BEG) && (h_ext < HS_END);
    // vsync depends on v only, so its edges land on h==0 automatically.
    vs_act = (v_ext >= VS_BEG) && (v_ext < VS_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= H_LAST[11:0];
      v_cnt       <= V_LAST[11:0];
      x           <= 12'd0;
      y           <= 12'd0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      x           <= h_nxt;
      y           <= v_nxt;
      de          <= de_nxt;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      line_start  <= (h_nxt == 12'd0);
      frame_start <= (h_nxt == 12'd0) && (v_nxt == 12'd0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small raster (14x7) plus one line of
// the default 1344-wide raster.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;

  logic [11:0] x, y, x_d, y_d;
  logic de, hsync, vsync, line_start, frame_start;
  logic de_d, hsync_d, vsync_d, line_start_d, frame_start_d;

  int passes = 0;
  int checks = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .de(de),
    .hsync(hsync), .vsync(vsync), .line_start(line_start),
    .frame_start(frame_start)
  );

  video_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x_d), .y(y_d), .de(de_d),
    .hsync(hsync_d), .vsync(vsync_d), .line_start(line_start_d),
    .frame_start(frame_start_d)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int ede,
                         input int ehs, input int evs, input int els, input int efs);
    chk({tag, ".x"}, int'(x), ex);
    chk({tag, ".y"}, int'(y), ey);
    chk({tag, ".de"}, int'(de), ede);
    chk({tag, ".hsync"}, int'(hsync), ehs);
    chk({tag, ".vsync"}, int'(vsync), evs);
    chk({tag, ".line_start"}, int'(line_start), els);
    chk({tag, ".frame_start"}, int'(frame_start), efs);
  endtask

  initial begin
    int ex, ey, n, de_cnt, hs_cnt;

    // 1: reset, then release
    rst_n = 1'b0; en = 1'b1;
    step(); step();
    chk_all("reset", 0, 0, 0, 1, 1, 0, 0);
    rst_n = 1'b1;
    step();
    chk_all("first_pixel", 0, 0, 1, 1, 1, 1, 1);

    // 2: one line; active x=0..7, hsync low at x=10,11
    for (int i = 1; i < 14; i++) begin
      step();
      chk_all($sformatf("line0_x%0d", i), i, 0, (i < 8) ? 1 : 0,
              (i == 10 || i == 11) ? 0 : 1, 1, 0, 0);
    end
    step();
    chk_all("line1_start", 0, 1, 1, 1, 1, 1, 0);

    // 3: rest of the frame; frame period is 98, so 84 more pixels
    ex = 0; ey = 1;
    for (int i = 0; i < 84; i++) begin
      step();
      ex++;
      if (ex == 14) begin
        ex = 0;
        ey++;
        if (ey == 7) ey = 0;
      end
      chk_all($sformatf("frame_y%0d_x%0d", ey, ex), ex, ey,
              (ex < 8 && ey < 4) ? 1 : 0,
              (ex == 10 || ex == 11) ? 0 : 1,
              (ey == 5) ? 0 : 1,
              (ex == 0) ? 1 : 0,
              (ex == 0 && ey == 0) ? 1 : 0);
    end
    chk("frame_wrap_pos", int'(x) + 16 * int'(y), 0);

    // 4: en gaps hold every output, strobe stretches over the gap
    en = 1'b0; step();
    chk_all("gap0", 0, 0, 1, 1, 1, 1, 1);
    en = 1'b1; step();
    chk_all("adv1", 1, 0, 1, 1, 1, 0, 0);
    en = 1'b0; step();
    chk_all("gap1", 1, 0, 1, 1, 1, 0, 0);
    en = 1'b1; step();
    chk_all("adv2", 2, 0, 1, 1, 1, 0, 0);

    // 5: reset mid-frame at x=11,y=5 with both syncs active
    n = 0;
    while (!(x == 12'd11 && y == 12'd5) && n < 200) begin
      step();
      n++;
    end
    chk("reach_x11_y5_steps", n, 79);
    chk_all("pre_reset", 11, 5, 0, 0, 0, 0, 0);
    rst_n = 1'b0; step();
    chk_all("mid_reset", 0, 0, 0, 1, 1, 0, 0);
    rst_n = 1'b1; en = 1'b0; step();
    chk_all("post_reset_idle", 0, 0, 0, 1, 1, 0, 0);
    en = 1'b1; step();
    chk_all("post_reset_first", 0, 0, 1, 1, 1, 1, 1);

    // 6: default raster, one full line of 1344 pixels
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("def_first_fs", int'(frame_start_d), 1);
    chk("def_first_ls", int'(line_start_d), 1);
    de_cnt = int'(de_d);
    hs_cnt = (hsync_d == 1'b0) ? 1 : 0;
    for (int i = 1; i < 1344; i++) begin
      step();
      if (de_d) de_cnt++;
      if (!hsync_d) hs_cnt++;
    end
    chk("def_last_x", int'(x_d), 1343);
    chk("def_de_per_line", de_cnt, 1024);
    chk("def_hsync_width", hs_cnt, 20);
    chk("def_vsync_line0", int'(vsync_d), 1);
    step();
    chk("def_line1_x", int'(x_d), 0);
    chk("def_line1_y", int'(y_d), 1);
    chk("def_line1_ls", int'(line_start_d), 1);
    chk("def_line1_fs", int'(frame_start_d), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
